tqvp_hx2003_multi_pulse_transmitter: RTL and testbench

- Multi-channel, parametrised pulse/symbol transmitter peripheral on the TinyQV peripheral bus.
- Each channel walks its own window of 2-bit symbols in a shared symbol memory.
- Each symbol selects one of four programmable durations and an output level.
- Optional shared carrier modulation per channel; finite or infinite repeat counts; readable status; W1C done interrupt.

---
 rtl/tqvp_hx2003_multi_pulse_transmitter_if.sv | 19 +
 rtl/tqvp_hx2003_multi_pulse_transmitter.sv | 222 ++++++++++++++++++++++
 tb/tb_tqvp_hx2003_multi_pulse_transmitter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/tqvp_hx2003_multi_pulse_transmitter_if.sv
// rtl/tqvp_hx2003_multi_pulse_transmitter_if.sv - TinyQV peripheral bus bundle for the pulse transmitter
interface tqvp_hx2003_multi_pulse_transmitter_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready
    );
endinterface

// File: rtl/tqvp_hx2003_multi_pulse_transmitter.sv
// rtl/tqvp_hx2003_multi_pulse_transmitter.sv - multi-channel 2-bit symbol pulse transmitter; carrier generator enabled by PULSE_TX_CARRIER_EN
module tqvp_hx2003_multi_pulse_transmitter #(
    parameter int NUM_CHANNELS = 2,
    parameter int DATA_WORDS   = 8,
    parameter int DUR_WIDTH    = 8,
    parameter int LOOP_WIDTH   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    output logic       user_interrupt,
    tqvp_hx2003_multi_pulse_transmitter_if.slave bus
);
    localparam int PCW = $clog2(DATA_WORDS * 16);
    localparam int AW  = PCW - 4;
    localparam int TW  = DUR_WIDTH + 16;
`ifdef PULSE_TX_CARRIER_EN
    localparam logic [29:0] CTRL_MASK = 30'h3fff_ffff;
`else
    // carrier_en is not stored when there is no carrier, so it reads back 0
    localparam logic [29:0] CTRL_MASK = 30'h3fff_fff7;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_RUN} state_t;

    logic [31:0]             mem [DATA_WORDS];
    logic [4*DUR_WIDTH-1:0]  dur_q;
    logic [29:0]             ctrl_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] int_en_q, done_q, start_q, level_q;
    state_t                  state_q [NUM_CHANNELS];
    logic [PCW-1:0]          pc_q [NUM_CHANNELS];
    logic [LOOP_WIDTH-1:0]   loops_q [NUM_CHANNELS];
    logic [TW-1:0]           tmr_q [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0] start, busy, at_end, last_loop, ch_out;
    logic [PCW-1:0]          next_pc [NUM_CHANNELS];
    logic [PCW-1:0]          fetch_pc [NUM_CHANNELS];
    logic [31:0]             fetch_word [NUM_CHANNELS];
    logic [1:0]              fetch_sym [NUM_CHANNELS];
    logic [TW-1:0]           tmr_load [NUM_CHANNELS];
    logic                    carrier;
    logic [15:0]             half_rd;
    logic [31:0]             rd_data;
    logic                    wr32, wr_mem, wr_reg;
    logic [2:0]              reg_idx;
    logic                    unused_ok;

    assign wr32      = bus.data_write_n == 2'b10;
    assign wr_mem    = wr32 && bus.address[5];
    assign wr_reg    = wr32 && !bus.address[5];
    assign reg_idx   = bus.address[4:2];
    assign unused_ok = &{1'b0, ui_in, bus.address[1:0]};

    // Per-channel next-symbol selection: FETCH reads the current pc, RUN prefetches the following one
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            start[c]      = ctrl_q[c][0];
            busy[c]       = state_q[c] != ST_IDLE;
            at_end[c]     = pc_q[c] == ctrl_q[c][11 +: PCW];
            last_loop[c]  = at_end[c] && (ctrl_q[c][18 +: LOOP_WIDTH] != '0)
                            && (loops_q[c] <= LOOP_WIDTH'(1));
            next_pc[c]    = at_end[c] ? ctrl_q[c][4 +: PCW] : pc_q[c] + PCW'(1);
            fetch_pc[c]   = (state_q[c] == ST_FETCH) ? pc_q[c] : next_pc[c];
            fetch_word[c] = mem[fetch_pc[c][PCW-1:4]];
            fetch_sym[c]  = fetch_word[c][{fetch_pc[c][3:0], 1'b0} +: 2];
            tmr_load[c]   = ((TW'(dur_q[fetch_sym[c] * DUR_WIDTH +: DUR_WIDTH]) + TW'(1))
                             << ctrl_q[c][29:26]) - TW'(1);
            // A cleared start bit forces idle immediately, one cycle ahead of the FSM
            ch_out[c]     = (((state_q[c] == ST_RUN) && ctrl_q[c][0])
                             ? (level_q[c] & (~ctrl_q[c][3] | carrier))
                             : ctrl_q[c][1]) ^ ctrl_q[c][2];
        end
    end

    // Symbol memory: 32-bit writes only, not reset
    always_ff @(posedge clk) begin
        if (wr_mem) mem[bus.address[2 +: AW]] <= bus.data_in;
    end

    // Configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur_q    <= '0;
            int_en_q <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) ctrl_q[c] <= '0;
        end else if (wr_reg) begin
            if (reg_idx == 3'd0) dur_q <= bus.data_in[4*DUR_WIDTH-1:0];
            if (reg_idx == 3'd2) int_en_q <= bus.data_in[NUM_CHANNELS-1:0];
            for (int c = 0; c < NUM_CHANNELS; c++)
                if (reg_idx == 3'(4 + 2 * c)) ctrl_q[c] <= bus.data_in[29:0] & CTRL_MASK;
        end
    end

    // Channel sequencers: IDLE -> FETCH -> RUN -> (RUN | IDLE), plus sticky done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
            level_q <= '0;
            done_q  <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= ST_IDLE;
                pc_q[c]    <= '0;
                loops_q[c] <= '0;
                tmr_q[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                start_q[c] <= start[c];
                if (wr_reg && reg_idx == 3'd2 && bus.data_in[8 + c]) done_q[c] <= 1'b0;
                case (state_q[c])
                    ST_IDLE: begin
                        if (start[c] && !start_q[c]) begin
                            pc_q[c]    <= '0;
                            loops_q[c] <= ctrl_q[c][18 +: LOOP_WIDTH];
                            state_q[c] <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (!start[c]) begin
                            state_q[c] <= ST_IDLE;
                        end else begin
                            level_q[c] <= fetch_sym[c][1];
                            tmr_q[c]   <= tmr_load[c];
                            state_q[c] <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (!start[c]) begin
                            state_q[c] <= ST_IDLE;
                        end else if (tmr_q[c] == '0) begin
                            if (last_loop[c]) begin
                                state_q[c] <= ST_IDLE;
                                done_q[c]  <= 1'b1;
                            end else begin
                                if (at_end[c] && ctrl_q[c][18 +: LOOP_WIDTH] != '0)
                                    loops_q[c] <= loops_q[c] - LOOP_WIDTH'(1);
                                pc_q[c]    <= next_pc[c];
                                level_q[c] <= fetch_sym[c][1];
                                tmr_q[c]   <= tmr_load[c];
                            end
                        end else begin
                            tmr_q[c] <= tmr_q[c] - TW'(1);
                        end
                    end
                    default: state_q[c] <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef PULSE_TX_CARRIER_EN
    logic [15:0] half_q, cnt_q;
    logic        carrier_q;

    // Shared carrier: reload H and toggle at zero; parked low while no channel is started
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q    <= '0;
            cnt_q     <= '0;
            carrier_q <= 1'b0;
        end else begin
            if (wr_reg && reg_idx == 3'd1) half_q <= bus.data_in[15:0];
            if (start == '0) begin
                cnt_q     <= '0;
                carrier_q <= 1'b0;
            end else if (cnt_q == '0) begin
                cnt_q     <= half_q;
                carrier_q <= ~carrier_q;
            end else begin
                cnt_q <= cnt_q - 16'd1;
            end
        end
    end

    assign carrier = carrier_q;
    assign half_rd = half_q;
`else
    assign carrier = 1'b0;
    assign half_rd = '0;
`endif

    // Read mux, answered in the same cycle as the strobe
    always_comb begin
        rd_data = '0;
        if (bus.address[5]) begin
            rd_data = mem[bus.address[2 +: AW]];
        end else begin
            case (reg_idx)
                3'd0: rd_data = 32'(dur_q);
                3'd1: rd_data = {16'b0, half_rd};
                3'd2: begin
                    for (int c = 0; c < NUM_CHANNELS; c++) begin
                        rd_data[c]     = int_en_q[c];
                        rd_data[8 + c] = done_q[c];
                    end
                end
                default: begin
                    for (int c = 0; c < NUM_CHANNELS; c++) begin
                        if (reg_idx == 3'(4 + 2 * c)) rd_data = {2'b00, ctrl_q[c]};
                        if (reg_idx == 3'(5 + 2 * c)) begin
                            rd_data[PCW-1:0]         = pc_q[c];
                            rd_data[7 +: LOOP_WIDTH] = loops_q[c];
                            rd_data[16]              = busy[c];
                        end
                    end
                end
            endcase
        end
    end

    assign bus.data_out   = (bus.data_read_n != 2'b11) ? rd_data : 32'd0;
    assign bus.data_ready = 1'b1;
    assign user_interrupt = |(done_q & int_en_q);

    // Pin map: [1] carrier, [2+ch] channel outputs, everything else low
    always_comb begin
        uo_out    = '0;
        uo_out[1] = carrier;
        for (int c = 0; c < NUM_CHANNELS; c++) uo_out[2 + c] = ch_out[c];
    end
endmodule

// File: tb/tb_tqvp_hx2003_multi_pulse_transmitter.sv
// tb/tb_tqvp_hx2003_multi_pulse_transmitter.sv - directed self-checking bench for the pulse transmitter
module tb_tqvp_hx2003_multi_pulse_transmitter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic       user_interrupt;
    int         n_assert = 0;
    int         n_fail = 0;

    tqvp_hx2003_multi_pulse_transmitter_if bus();

    tqvp_hx2003_multi_pulse_transmitter #(
        .NUM_CHANNELS(2), .DATA_WORDS(8), .DUR_WIDTH(8), .LOOP_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
        .user_interrupt(user_interrupt), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        bus.address = a; bus.data_in = d; bus.data_write_n = 2'b10;
        @(posedge clk);
        #1;
        bus.data_write_n = 2'b11;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] v);
        bus.address = a; bus.data_read_n = 2'b00;
        #1;
        v = bus.data_out;
        bus.data_read_n = 2'b11;
    endtask

    function automatic logic [31:0] ctrl(input logic st, idl, inv, cen, input int lb, en, lc, p);
        return {2'b00, p[3:0], lc[7:0], en[6:0], lb[6:0], cen, inv, idl, st};
    endfunction

    initial begin
        logic [31:0] v;
        int found;
        ui_in = 8'h00;
        bus.address = '0; bus.data_in = '0; bus.data_write_n = 2'b11; bus.data_read_n = 2'b11;
        tick(2);
        check("reset_uo_out", 32'(uo_out), 32'h0);
        check("reset_irq", 32'(user_interrupt), 32'h0);
        check("reset_data_out", bus.data_out, 32'h0);
        rst_n = 1'b1;
        tick(1);
        rd(6'h14, v); check("reset_status0", v, 32'h0);
        rd(6'h08, v); check("reset_int", v, 32'h0);

        for (int w = 0; w < 8; w++) wr(6'h20 + 6'(4 * w), (w == 0) ? 32'hE4 : ((w == 7) ? 32'h8000_0000 : 32'h0));
        rd(6'h20, v); check("mem0_readback", v, 32'hE4);
        wr(6'h00, 32'h0302_0100);
        rd(6'h00, v); check("dur_readback", v, 32'h0302_0100);

        // basic: idle high, symbols 0,1,2,3 -> levels 0,0,1,1 lasting 1,2,3,4
        wr(6'h10, ctrl(1, 1, 0, 0, 0, 3, 1, 0));
        for (int k = 1; k <= 13; k++) begin
            tick(1);
            check("basic_level", 32'(uo_out[2]), (k == 1 || k >= 5) ? 32'd1 : 32'd0);
            if (k == 11) begin
                rd(6'h14, v); check("basic_status_busy", v, 32'h0001_0083);
            end
            if (k == 12) begin
                rd(6'h14, v); check("basic_status_idle", v, 32'h0000_0083);
                rd(6'h08, v); check("basic_done", v, 32'h100);
            end
        end
        check("basic_ch1_idle", 32'(uo_out[3]), 32'd0);

        // finite loop: pc0 (high, 4 cycles), pc1 (low, 2 cycles), three times
        wr(6'h10, ctrl(0, 0, 0, 0, 0, 1, 3, 0));
        wr(6'h20, 32'h7);
        wr(6'h08, 32'h101);
        check("loop_irq_cleared", 32'(user_interrupt), 32'd0);
        wr(6'h10, ctrl(1, 0, 0, 0, 0, 1, 3, 0));
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (k == 2) begin
                rd(6'h14, v); check("loop_st_k2", v, 32'h0001_0180);
                check("loop_lvl_k2", 32'(uo_out[2]), 32'd1);
            end
            if (k == 6) begin
                rd(6'h14, v); check("loop_st_k6", v, 32'h0001_0181);
                check("loop_lvl_k6", 32'(uo_out[2]), 32'd0);
            end
            if (k == 8) begin
                rd(6'h14, v); check("loop_st_k8", v, 32'h0001_0100);
                check("loop_lvl_k8", 32'(uo_out[2]), 32'd1);
            end
            if (k == 14) begin
                rd(6'h14, v); check("loop_st_k14", v, 32'h0001_0080);
            end
            if (k == 19) begin
                check("loop_lvl_k19", 32'(uo_out[2]), 32'd0);
                check("loop_irq_k19", 32'(user_interrupt), 32'd0);
            end
            if (k == 20) begin
                rd(6'h14, v); check("loop_st_done", v, 32'h0000_0081);
                check("loop_irq_set", 32'(user_interrupt), 32'd1);
                rd(6'h08, v); check("loop_int_reg", v, 32'h101);
            end
        end
        wr(6'h08, 32'h100);
        check("loop_irq_w1c", 32'(user_interrupt), 32'd0);
        rd(6'h08, v); check("loop_int_after_w1c", v, 32'h0);

        // prescaler 4, all durations 0, window 126..127 looping forever
        wr(6'h10, ctrl(0, 0, 0, 0, 0, 0, 0, 0));
        wr(6'h00, 32'h0);
        wr(6'h10, ctrl(1, 0, 0, 0, 126, 127, 0, 2));
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            tick(1);
            rd(6'h14, v);
            if (v[6:0] == 7'd127) found = 1;
        end
        check("wrap_reach_127", 32'(found), 32'd1);
        for (int i = 0; i < 16; i++) begin
            rd(6'h14, v);
            check("wrap_pc", 32'(v[6:0]), ((i / 4) % 2 == 0) ? 32'd127 : 32'd126);
            check("wrap_level", 32'(uo_out[2]), ((i / 4) % 2 == 0) ? 32'd1 : 32'd0);
            tick(1);
        end

        // ch1 inverted, toggling every cycle, alongside ch0
        wr(6'h18, ctrl(1, 0, 1, 0, 0, 1, 0, 0));
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check("ch1_level", 32'(uo_out[3]), 32'(k % 2));
            rd(6'h14, v);
            check("ch0_indep", 32'(uo_out[2]), (v[6:0] == 7'd127) ? 32'd1 : 32'd0);
        end
        wr(6'h18, ctrl(0, 0, 1, 0, 0, 1, 0, 0));
        check("abort_level_now", 32'(uo_out[3]), 32'd1);
        tick(1);
        check("abort_level_next", 32'(uo_out[3]), 32'd1);
        rd(6'h1C, v); check("abort_ch1_busy", 32'(v[16]), 32'd0);
        rd(6'h08, v); check("abort_no_done", v, 32'h0);
        rd(6'h14, v); check("abort_ch0_busy", 32'(v[16]), 32'd1);

        // ch1 short finite run to raise its interrupt
        wr(6'h08, 32'h002);
        wr(6'h18, ctrl(1, 0, 0, 0, 0, 0, 1, 0));
        tick(4);
        check("ch1_irq", 32'(user_interrupt), 32'd1);
        rd(6'h08, v); check("ch1_int_reg", v, 32'h202);

        // asynchronous reset while ch0 is driving high
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick(1);
            if (uo_out[2]) found = 1;
        end
        check("reset_pre_high", 32'(found), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("areset_uo_out", 32'(uo_out), 32'h0);
        check("areset_irq", 32'(user_interrupt), 32'd0);
        rd(6'h14, v); check("areset_status0", v, 32'h0);
        #2 rst_n = 1'b1;
        tick(1);

        // carrier: H=1, ch0 constant high symbol with carrier_en
        wr(6'h04, 32'h1);
        wr(6'h10, ctrl(1, 0, 0, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 9; k++) begin
            tick(1);
`ifdef PULSE_TX_CARRIER_EN
            check("car_pin", 32'(uo_out[1]), (k % 4 == 1 || k % 4 == 2) ? 32'd1 : 32'd0);
            if (k >= 2) check("car_mod_level", 32'(uo_out[2]), (k % 4 == 1 || k % 4 == 2) ? 32'd1 : 32'd0);
`else
            check("nocar_pin", 32'(uo_out[1]), 32'd0);
            if (k >= 2) check("nocar_level", 32'(uo_out[2]), 32'd1);
`endif
        end
        rd(6'h04, v);
`ifdef PULSE_TX_CARRIER_EN
        check("car_reg", v, 32'h1);
        rd(6'h10, v); check("car_ctrl", v, 32'h9);
`else
        check("nocar_reg", v, 32'h0);
        rd(6'h10, v); check("nocar_ctrl", v, 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
